// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin owner selection for a shared 4:1 mux path.
// The owner is held for at most MAX_HOLD consecutive cycles while another requester waits.
// All outputs come straight from flops, so no combinational path runs from req to any output.
module mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s,
  output logic       s0,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned REQ_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REQ_W-1:0]   gnt_q, gnt_d;
  logic               s_q, s_d;
  logic               s0_q, s0_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [REQ_W-1:0]   others;
  logic [IDX_W:0]     pick_all;
  logic [IDX_W:0]     pick_oth;
  logic               do_grant;
  logic               do_idle;
  logic [IDX_W-1:0]   grant_idx;

  // Round-robin search starting after the last grant; returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [REQ_W-1:0] cand,
                                             input logic [IDX_W-1:0] last);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 1; k <= REQ_W; k++) begin
      idx = last + IDX_W'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  // Arbitration candidates: all requesters, and all except the current owner.
  always_comb begin
    others   = req & ~(REQ_W'(1) << owner_q);
    pick_all = rr_pick(req, last_q);
    pick_oth = rr_pick(others, last_q);
  end

  // Next-state and next-output decision.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    s_d       = s_q;
    s0_d      = s0_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    do_grant  = 1'b0;
    do_idle   = 1'b0;
    grant_idx = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_all[IDX_W]) begin
          do_grant  = 1'b1;
          grant_idx = pick_all[IDX_W-1:0];
        end
      end
      ST_GRANT: begin
        if (!req[owner_q]) begin
          // Release takes precedence over a simultaneous hold limit: never a timeout.
          if (pick_oth[IDX_W]) begin
            do_grant  = 1'b1;
            grant_idx = pick_oth[IDX_W-1:0];
          end else begin
            do_idle = 1'b1;
          end
        end else if (cnt_q >= CNT_W'(MAX_HOLD)) begin
          if (pick_oth[IDX_W]) begin
            do_grant  = 1'b1;
            grant_idx = pick_oth[IDX_W-1:0];
            timeout_d = 1'b1;
          end else begin
            cnt_d = CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        do_idle = 1'b1;
      end
    endcase

    if (do_grant) begin
      state_d = ST_GRANT;
      owner_d = grant_idx;
      last_d  = grant_idx;
      cnt_d   = CNT_W'(1);
      gnt_d   = REQ_W'(1) << grant_idx;
      s_d     = grant_idx[1];
      s0_d    = grant_idx[0];
      busy_d  = 1'b1;
    end else if (do_idle) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      gnt_d   = '0;
      busy_d  = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      last_q    <= IDX_W'(3);
      cnt_q     <= '0;
      gnt_q     <= '0;
      s_q       <= 1'b0;
      s0_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      s_q       <= s_d;
      s0_q      <= s0_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign s       = s_q;
  assign s0      = s0_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: directed vector table plus hand-written sequences, MAX_HOLD=4.
module tb_mux4_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s;
  logic       s0;
  logic       busy;
  logic       timeout;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
    string      name;
  } vec_t;

  vec_t vecs[$];

  mux4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .s       (s),
    .s0      (s0),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants sampled on the falling edge every cycle.
  always @(negedge clk) begin
    int         nset;
    logic [1:0] idx;
    nset = 0;
    idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        nset++;
        idx = 2'(i);
      end
    end
    assert_cnt++;
    if (nset != (busy ? 1 : 0)) begin
      fail_cnt++;
      $display("FAIL onehot: gnt=%b busy=%b (need one bit when busy, none when idle)", gnt, busy);
    end
    if (busy) begin
      assert_cnt++;
      if ({s, s0} != idx) begin
        fail_cnt++;
        $display("FAIL sel_match: {s,s0}=%b gnt=%b need %b", {s, s0}, gnt, idx);
      end
    end
  end

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] sl, input logic b, input logic t,
                              input string nm);
    vec_t v;
    v.rst_n = r; v.req = q; v.gnt = g; v.sel = sl; v.busy = b; v.timeout = t; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, then compare the registered outputs just after the edge.
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] g,
                      input logic [1:0] sl, input logic b, input logic t, input string nm);
    rst_n = r;
    req   = q;
    @(posedge clk);
    #1;
    assert_cnt++;
    if (gnt !== g || {s, s0} !== sl || busy !== b || timeout !== t) begin
      fail_cnt++;
      $display("FAIL %s: gnt=%b sel=%b busy=%b timeout=%b need gnt=%b sel=%b busy=%b timeout=%b",
               nm, gnt, {s, s0}, busy, timeout, g, sl, b, t);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

    // Reset, then all requesters: requester 0 wins first.
    add(0, 4'b1111, 4'b0000, 2'b00, 0, 0, "reset");
    add(1, 4'b1111, 4'b0001, 2'b00, 1, 0, "first_grant");
    add(1, 4'b0000, 4'b0000, 2'b00, 0, 0, "release_idle");
    // Single requester held 10 cycles: no preemption without contention.
    for (int i = 0; i < 10; i++)
      add(1, 4'b0100, 4'b0100, 2'b10, 1, 0, "single_hold");
    add(1, 4'b0000, 4'b0000, 2'b10, 0, 0, "single_drop_sel_holds");
    // Two requesters contend: rotate every MAX_HOLD cycles with a timeout pulse.
    add(0, 4'b1001, 4'b0000, 2'b00, 0, 0, "reset2");
    for (int i = 0; i < 16; i++)
      add(1, 4'b1001, ((i / 4) % 2 == 0) ? 4'b0001 : 4'b1000,
          ((i / 4) % 2 == 0) ? 2'b00 : 2'b11, 1, (i % 4 == 0 && i > 0) ? 1'b1 : 1'b0,
          "rotate");
    // Owner 1 releases while 0 and 2 request: hand-over with no idle cycle.
    add(1, 4'b0000, 4'b0000, 2'b11, 0, 0, "idle_before_owner1");
    add(1, 4'b0010, 4'b0010, 2'b01, 1, 0, "owner1_grant");
    add(1, 4'b0111, 4'b0010, 2'b01, 1, 0, "owner1_hold");
    add(1, 4'b0101, 4'b0100, 2'b10, 1, 0, "owner1_release_handover");
    // Owner 0 releases exactly on its MAX_HOLD cycle while 2 waits: release, no timeout.
    add(1, 4'b0001, 4'b0001, 2'b00, 1, 0, "owner0_grant");
    add(1, 4'b0101, 4'b0001, 2'b00, 1, 0, "owner0_cnt2");
    add(1, 4'b0101, 4'b0001, 2'b00, 1, 0, "owner0_cnt3");
    add(1, 4'b0101, 4'b0001, 2'b00, 1, 0, "owner0_cnt4");
    add(1, 4'b0100, 4'b0100, 2'b10, 1, 0, "release_at_limit");

    foreach (vecs[i])
      step(vecs[i].rst_n, vecs[i].req, vecs[i].gnt, vecs[i].sel, vecs[i].busy,
           vecs[i].timeout, vecs[i].name);

    // Released owner re-requests while another is pending: it waits its turn.
    step(1, 4'b1000, 4'b1000, 2'b11, 1, 0, "handover_to_3");
    step(1, 4'b1100, 4'b1000, 2'b11, 1, 0, "owner3_hold_2waits");
    step(1, 4'b0100, 4'b0100, 2'b10, 1, 0, "owner3_release");
    step(1, 4'b1100, 4'b0100, 2'b10, 1, 0, "owner2_keeps");

    // Reset in the middle of a grant drops it; priority restarts at requester 0.
    step(1, 4'b1000, 4'b1000, 2'b11, 1, 0, "pre_reset_owner3");
    step(1, 4'b1111, 4'b1000, 2'b11, 1, 0, "pre_reset_hold");
    step(0, 4'b1111, 4'b0000, 2'b00, 0, 0, "mid_grant_reset");
    step(1, 4'b1111, 4'b0001, 2'b00, 1, 0, "post_reset_priority");
    step(1, 4'b1111, 4'b0001, 2'b00, 1, 0, "post_reset_hold2");
    step(1, 4'b1111, 4'b0001, 2'b00, 1, 0, "post_reset_hold3");
    step(1, 4'b1111, 4'b0001, 2'b00, 1, 0, "post_reset_hold4");
    step(1, 4'b1111, 4'b0010, 2'b01, 1, 1, "preempt_to_1");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
